// File: rtl/decode_pkg.sv
// Shared constants and types for the prefix/decode byte window.
package decode_pkg;

  localparam int DEF_WINDOW_BYTES = 12;
  localparam int DEF_FETCH_BYTES  = 8;
  localparam int DEF_PREFIX_LIMIT = 14;

  // Legacy prefix bytes and the two-byte opcode escape
  localparam logic [7:0] PFX_ES    = 8'h26;
  localparam logic [7:0] PFX_CS    = 8'h2E;
  localparam logic [7:0] PFX_SS    = 8'h36;
  localparam logic [7:0] PFX_DS    = 8'h3E;
  localparam logic [7:0] PFX_FS    = 8'h64;
  localparam logic [7:0] PFX_GS    = 8'h65;
  localparam logic [7:0] PFX_OPSZ  = 8'h66;
  localparam logic [7:0] PFX_ADSZ  = 8'h67;
  localparam logic [7:0] PFX_LOCK  = 8'hF0;
  localparam logic [7:0] PFX_REPNE = 8'hF2;
  localparam logic [7:0] PFX_REP   = 8'hF3;
  localparam logic [7:0] ESC_0F    = 8'h0F;

  localparam logic [2:0] SEG_ES   = 3'd0;
  localparam logic [2:0] SEG_CS   = 3'd1;
  localparam logic [2:0] SEG_SS   = 3'd2;
  localparam logic [2:0] SEG_DS   = 3'd3;
  localparam logic [2:0] SEG_FS   = 3'd4;
  localparam logic [2:0] SEG_GS   = 3'd5;
  localparam logic [2:0] SEG_NONE = 3'd7;

  localparam logic [1:0] REP_NONE = 2'b00;
  localparam logic [1:0] REP_F2   = 2'b01;
  localparam logic [1:0] REP_F3   = 2'b10;

  typedef enum logic {ST_PREFIX, ST_OPCODE} state_e;

  typedef struct packed {
    logic       lock;
    logic [1:0] rep;
    logic [2:0] seg;
    logic       opsz;
    logic       adsz;
    logic       two_byte;
  } prefix_t;

  localparam prefix_t PFX_CLEAR = '{lock: 1'b0, rep: REP_NONE, seg: SEG_NONE,
                                    opsz: 1'b0, adsz: 1'b0, two_byte: 1'b0};

  function automatic logic is_prefix(input logic [7:0] b);
    return b inside {PFX_ES, PFX_CS, PFX_SS, PFX_DS, PFX_FS, PFX_GS,
                     PFX_OPSZ, PFX_ADSZ, PFX_LOCK, PFX_REPNE, PFX_REP};
  endfunction

endpackage

// File: rtl/decode_window_shifter.sv
// Byte datapath: drop `shift` leading bytes, keep `keep` survivors, then
// append `app` fetch bytes right behind them. Unused bytes come out zero.
module decode_window_shifter #(
  parameter int NB = 12,
  parameter int FB = 8,
  parameter int CW = 4
) (
  input  logic [NB-1:0][7:0] win,
  input  logic [CW-1:0]      shift,
  input  logic [CW-1:0]      keep,
  input  logic [CW-1:0]      app,
  input  logic [FB-1:0][7:0] fetch,
  output logic [NB-1:0][7:0] nxt
);

  logic [8*NB-1:0] kept, ins;
  logic [8*FB-1:0] fetch_m;

  // Shift-down of survivors OR'd with fetch bytes placed at the new tail
  always_comb begin
    kept    = win >> {shift, 3'b000};
    kept    = kept & ~({(8*NB){1'b1}} << {keep, 3'b000});
    fetch_m = fetch & ~({(8*FB){1'b1}} << {app, 3'b000});
    ins     = (8*NB)'(fetch_m) << {keep, 3'b000};
    nxt     = kept | ins;
  end

endmodule

// File: rtl/decode_prefix_window.sv
// Byte window between prefetch and command decode. Strips legacy prefixes
// one per cycle into registered state, then holds the body for the decoder.
// Optional DECODE_WINDOW_STATS_EN adds instruction and fetch-stall counters.
module decode_prefix_window
  import decode_pkg::*;
#(
  parameter int WINDOW_BYTES = DEF_WINDOW_BYTES,
  parameter int FETCH_BYTES  = DEF_FETCH_BYTES,
  parameter int PREFIX_LIMIT = DEF_PREFIX_LIMIT,
  localparam int CW  = $clog2(WINDOW_BYTES + 1),
  localparam int PLW = $clog2(PREFIX_LIMIT + 1) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dec_flush,
  input  logic                        code_32bit,
  input  logic [CW-1:0]               fetch_valid,
  input  logic [8*FETCH_BYTES-1:0]    fetch,
  output logic                        fetch_accept,
  input  logic [CW-1:0]               consume_count,
  output logic [8*WINDOW_BYTES-1:0]   decoder,
  output logic [CW-1:0]               decoder_count,
  output logic                        dec_ready,
  output logic                        prefix_group_1_lock,
  output logic [1:0]                  dec_prefix_group_1_rep,
  output logic [2:0]                  dec_prefix_group_2_seg,
  output logic                        dec_operand_32bit,
  output logic                        dec_address_32bit,
  output logic                        dec_prefix_2byte,
  output logic                        dec_prefix_limit
`ifdef DECODE_WINDOW_STATS_EN
  ,
  output logic [31:0]                 stat_instr_count,
  output logic [31:0]                 stat_stall_cycles
`endif
);

  localparam logic [CW-1:0]  WB      = CW'(WINDOW_BYTES);
  localparam logic [PLW-1:0] PLIM    = PLW'(PREFIX_LIMIT);
  localparam logic [PLW-1:0] PLEN_MX = '1;

  state_e                       state, state_nxt;
  prefix_t                      pfx, pfx_nxt;
  logic [PLW-1:0]               plen, plen_nxt;
  logic                         limit;
  logic [CW-1:0]                count, count_nxt, shift, keep, free, app;
  logic [WINDOW_BYTES-1:0][7:0] win, win_nxt;
  logic [7:0]                   b0;

  assign b0 = win[0];

  // Scan byte0 in PREFIX, wait for retire in OPCODE
  always_comb begin
    state_nxt = state;
    pfx_nxt   = pfx;
    plen_nxt  = plen;
    shift     = '0;
    case (state)
      ST_PREFIX: begin
        if (count != '0) begin
          if (is_prefix(b0)) begin
            shift    = CW'(1);
            plen_nxt = (plen == PLEN_MX) ? plen : plen + PLW'(1);
            case (b0)
              PFX_ES:    pfx_nxt.seg  = SEG_ES;
              PFX_CS:    pfx_nxt.seg  = SEG_CS;
              PFX_SS:    pfx_nxt.seg  = SEG_SS;
              PFX_DS:    pfx_nxt.seg  = SEG_DS;
              PFX_FS:    pfx_nxt.seg  = SEG_FS;
              PFX_GS:    pfx_nxt.seg  = SEG_GS;
              PFX_OPSZ:  pfx_nxt.opsz = 1'b1;
              PFX_ADSZ:  pfx_nxt.adsz = 1'b1;
              PFX_LOCK:  pfx_nxt.lock = 1'b1;
              PFX_REPNE: pfx_nxt.rep  = REP_F2;
              PFX_REP:   pfx_nxt.rep  = REP_F3;
              default:   ;
            endcase
          end else if (b0 == ESC_0F) begin
            shift            = CW'(1);
            pfx_nxt.two_byte = 1'b1;
            state_nxt        = ST_OPCODE;
          end else begin
            state_nxt = ST_OPCODE;
          end
        end
      end
      ST_OPCODE: begin
        if (consume_count != '0) begin
          shift     = consume_count;
          pfx_nxt   = PFX_CLEAR;
          plen_nxt  = '0;
          state_nxt = ST_PREFIX;
        end
      end
      default: state_nxt = ST_PREFIX;
    endcase
  end

  // Space is judged after this cycle's shift so retire and refill overlap
  always_comb begin
    keep         = count - shift;
    free         = WB - keep;
    fetch_accept = (fetch_valid != '0) && !dec_flush && (free >= fetch_valid);
    app          = fetch_accept ? fetch_valid : '0;
    count_nxt    = keep + app;
  end

  decode_window_shifter #(.NB(WINDOW_BYTES), .FB(FETCH_BYTES), .CW(CW)) u_shift (
    .win   (win),
    .shift (shift),
    .keep  (keep),
    .app   (app),
    .fetch (fetch),
    .nxt   (win_nxt)
  );

  // Window, FSM and prefix registers; flush beats consume and fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_PREFIX;
      count <= '0;
      win   <= '0;
      pfx   <= PFX_CLEAR;
      plen  <= '0;
      limit <= 1'b0;
    end else if (dec_flush) begin
      state <= ST_PREFIX;
      count <= '0;
      win   <= '0;
      pfx   <= PFX_CLEAR;
      plen  <= '0;
      limit <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      win   <= win_nxt;
      pfx   <= pfx_nxt;
      plen  <= plen_nxt;
      limit <= (plen_nxt >= PLIM);
    end
  end

  assign decoder                = win;
  assign decoder_count          = count;
  assign dec_ready              = (state == ST_OPCODE) && (count != '0);
  assign prefix_group_1_lock    = pfx.lock;
  assign dec_prefix_group_1_rep = pfx.rep;
  assign dec_prefix_group_2_seg = pfx.seg;
  assign dec_operand_32bit      = code_32bit ^ pfx.opsz;
  assign dec_address_32bit      = code_32bit ^ pfx.adsz;
  assign dec_prefix_2byte       = pfx.two_byte;
  assign dec_prefix_limit       = limit;

`ifdef DECODE_WINDOW_STATS_EN
  // Free-running counters; survive flush, wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_instr_count  <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (state == ST_OPCODE && consume_count != '0 && !dec_flush)
        stat_instr_count <= stat_instr_count + 32'd1;
      if (fetch_valid != '0 && !fetch_accept)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_consume_legal: assert property (@(posedge clk) disable iff (rst)
    (consume_count != '0) |-> (dec_ready && consume_count <= count));
`endif

endmodule

// File: tb/tb_decode_prefix_window.sv
// Directed bench: stimulus queues cycle-tagged expectations, a negedge
// monitor pops and compares whatever is due in the current cycle.
module tb_decode_prefix_window;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_flush;
  logic        code_32bit;
  logic [3:0]  fetch_valid;
  logic [63:0] fetch;
  logic        fetch_accept;
  logic [3:0]  consume_count;
  logic [95:0] decoder;
  logic [3:0]  decoder_count;
  logic        dec_ready;
  logic        lock;
  logic [1:0]  rep;
  logic [2:0]  seg;
  logic        op32, ad32, two_byte, plimit;
`ifdef DECODE_WINDOW_STATS_EN
  logic [31:0] stat_instr_count, stat_stall_cycles;
`endif

  decode_prefix_window dut (
    .clk                    (clk),
    .rst                    (rst),
    .dec_flush              (dec_flush),
    .code_32bit             (code_32bit),
    .fetch_valid            (fetch_valid),
    .fetch                  (fetch),
    .fetch_accept           (fetch_accept),
    .consume_count          (consume_count),
    .decoder                (decoder),
    .decoder_count          (decoder_count),
    .dec_ready              (dec_ready),
    .prefix_group_1_lock    (lock),
    .dec_prefix_group_1_rep (rep),
    .dec_prefix_group_2_seg (seg),
    .dec_operand_32bit      (op32),
    .dec_address_32bit      (ad32),
    .dec_prefix_2byte       (two_byte),
    .dec_prefix_limit       (plimit)
`ifdef DECODE_WINDOW_STATS_EN
    ,
    .stat_instr_count       (stat_instr_count),
    .stat_stall_cycles      (stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  localparam int K_ACC = 0, K_CNT = 1, K_DEC = 2, K_B0 = 3, K_RDY = 4, K_LOCK = 5,
                 K_REP = 6, K_SEG = 7, K_OP = 8, K_AD = 9, K_2B = 10, K_LIM = 11;

  typedef struct {
    int          cyc;
    string       name;
    int          kind;
    logic [95:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [95:0] actual(input int k);
    case (k)
      K_ACC:  return 96'(fetch_accept);
      K_CNT:  return 96'(decoder_count);
      K_DEC:  return decoder;
      K_B0:   return 96'(decoder[7:0]);
      K_RDY:  return 96'(dec_ready);
      K_LOCK: return 96'(lock);
      K_REP:  return 96'(rep);
      K_SEG:  return 96'(seg);
      K_OP:   return 96'(op32);
      K_AD:   return 96'(ad32);
      K_2B:   return 96'(two_byte);
      default: return 96'(plimit);
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle; stale ones are misses
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        n_chk++;
        if (actual(q[i].kind) !== q[i].val) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %h want %h", q[i].name, cyc,
                   actual(q[i].kind), q[i].val);
        end
        q.delete(i);
      end else if (q[i].cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s: never sampled (due cyc %0d)", q[i].name, q[i].cyc);
        q.delete(i);
      end
    end
  end

  task automatic chk(input int d, input string nm, input int k, input logic [95:0] v);
    exp_t e;
    e.cyc = cyc + d; e.name = nm; e.kind = k; e.val = v;
    q.push_back(e);
  endtask

  task automatic idle();
    fetch_valid = '0; fetch = '0; consume_count = '0; dec_flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic drv(input logic [3:0] n, input logic [63:0] b);
    fetch_valid = n; fetch = b;
  endtask

  initial begin
    rst = 1'b1; code_32bit = 1'b0; idle();
    repeat (3) @(posedge clk); #1;
    chk(0, "rst_cnt", K_CNT, 0);    chk(0, "rst_dec", K_DEC, 0);
    chk(0, "rst_seg", K_SEG, 7);    chk(0, "rst_rdy", K_RDY, 0);
    chk(0, "rst_lim", K_LIM, 0);    chk(0, "rst_rep", K_REP, 0);
    chk(0, "rst_lock", K_LOCK, 0);  chk(0, "rst_2b", K_2B, 0);
    @(negedge clk); rst = 1'b0;

    // 66 2E 8B ...: two prefixes, then opcode 8B
    step(); drv(8, 64'h44332211_058B2E66); chk(0, "t1_acc", K_ACC, 1);
    step(); step();
    step(); chk(0, "t1_op", K_OP, 1); chk(0, "t1_seg", K_SEG, 1);
            chk(0, "t1_b0", K_B0, 8'h8B); chk(0, "t1_ad", K_AD, 0); chk(0, "t1_cnt", K_CNT, 6);
    // OPCODE, count 6: retire all 6 and fetch 8 together
    step(); chk(0, "t1_rdy", K_RDY, 1);
            consume_count = 4'd6; drv(8, 64'hB5B4B3B2_B1B0A20F); chk(0, "t2_acc", K_ACC, 1);
    step(); chk(0, "t2_cnt", K_CNT, 8); chk(0, "t2_op", K_OP, 0); chk(0, "t2_seg", K_SEG, 7);
            chk(0, "t2_rdy", K_RDY, 0); chk(0, "t2_dec", K_DEC, 96'h00000000_B5B4B3B2_B1B0A20F);
    // 0F escape consumed, A2 is opcode
    step(); chk(0, "t4_2b", K_2B, 1); chk(0, "t4_b0", K_B0, 8'hA2);
            chk(0, "t4_rdy", K_RDY, 1); chk(0, "t4_cnt", K_CNT, 7);
            drv(3, 64'h0000000000C2C1C0); chk(0, "t3_fill_acc", K_ACC, 1);
    // count 10: 4 bytes do not fit without a retire, fit with consume 2
    step(); chk(0, "t3_cnt10", K_CNT, 10); drv(4, 64'h00000000D3D2D1D0); chk(0, "t3_full_acc", K_ACC, 0);
    step(); consume_count = 4'd2; drv(4, 64'h00000000D3D2D1D0); chk(0, "t3_cons_acc", K_ACC, 1);
    step(); chk(0, "t3_cnt12", K_CNT, 12); chk(0, "t3_2b_clr", K_2B, 0);
            chk(0, "t3_dec", K_DEC, 96'hD3D2D1D0_C2C1C0B5_B4B3B2B1);
    step(); chk(0, "t3_rdy", K_RDY, 1); consume_count = 4'd12;
    step(); chk(0, "t3_empty", K_CNT, 0); chk(0, "t3_rdy0", K_RDY, 0);
    // 14 x 26 then 90: prefix-limit run
            drv(8, 64'h26262626_26262626); chk(0, "t5_acc0", K_ACC, 1);
    step(); drv(7, 64'h00902626_26262626); chk(0, "t5_bp0", K_ACC, 0);
    step(); drv(7, 64'h00902626_26262626); chk(0, "t5_bp1", K_ACC, 0);
    step(); drv(7, 64'h00902626_26262626); chk(0, "t5_acc1", K_ACC, 1);
    repeat (11) step();
    chk(0, "t5_lim13", K_LIM, 0);
    step(); chk(0, "t5_lim", K_LIM, 1); chk(0, "t5_rdy0", K_RDY, 0); chk(0, "t5_seg", K_SEG, 0);
            chk(0, "t5_b0", K_B0, 8'h90); chk(0, "t5_cnt", K_CNT, 1);
    step(); chk(0, "t5_rdy", K_RDY, 1); chk(0, "t5_lim_hold", K_LIM, 1); consume_count = 4'd1;
    step(); chk(0, "t5_lim_clr", K_LIM, 0); chk(0, "t5_seg_clr", K_SEG, 7);
    // F3 F0 then flush mid-run
            drv(8, 64'h26262626_2626F0F3); chk(0, "t6_acc", K_ACC, 1);
    step(); step();
    step(); chk(0, "t6_rep", K_REP, 2); chk(0, "t6_lock", K_LOCK, 1);
            dec_flush = 1'b1; drv(8, 64'h11111111_11111111); chk(0, "t6_flush_acc", K_ACC, 0);
    step(); chk(0, "t6_cnt", K_CNT, 0); chk(0, "t6_rep0", K_REP, 0); chk(0, "t6_lock0", K_LOCK, 0);
            chk(0, "t6_seg", K_SEG, 7); chk(0, "t6_dec", K_DEC, 0);
    // D bit set: 67 flips address size back, operand stays 32-bit
            code_32bit = 1'b1; drv(2, 64'h00000000_00009067); chk(0, "t7_acc", K_ACC, 1);
    step();
    step(); chk(0, "t7_ad", K_AD, 0); chk(0, "t7_op", K_OP, 1); chk(0, "t7_b0", K_B0, 8'h90);
            chk(0, "t7_cnt", K_CNT, 1);
    repeat (3) step();
    @(negedge clk); #1;
    foreach (q[i]) begin
      n_chk++; n_fail++;
      $display("FAIL %s: left unchecked", q[i].name);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
